// File: rtl/change_pulse_gen_if.sv
// Signal bundle between the raw-level source and change_pulse_gen.
// CHANGE_GEN_PULSE_CNT_EN adds the pulse_cnt / cnt_clr pair.
interface change_pulse_gen_if #(
    parameter int RPT_W = 16
);
    logic             raw_in;
    logic [1:0]       edge_sel;
    logic             hold_en;
    logic [RPT_W-1:0] rpt_period;
    logic             change;
    logic             level;
    logic             busy;
`ifdef CHANGE_GEN_PULSE_CNT_EN
    logic             cnt_clr;
    logic [15:0]      pulse_cnt;

    modport master (
        output raw_in, edge_sel, hold_en, rpt_period, cnt_clr,
        input  change, level, busy, pulse_cnt
    );
    modport slave (
        input  raw_in, edge_sel, hold_en, rpt_period, cnt_clr,
        output change, level, busy, pulse_cnt
    );
`else
    modport master (
        output raw_in, edge_sel, hold_en, rpt_period,
        input  change, level, busy
    );
    modport slave (
        input  raw_in, edge_sel, hold_en, rpt_period,
        output change, level, busy
    );
`endif
endinterface

// File: rtl/change_pulse_gen.sv
// Synchroniser + debounce FSM + edge select + auto-repeat producing one-cycle change strobes.
// Define CHANGE_GEN_PULSE_CNT_EN to add the saturating pulse_cnt output and its cnt_clr input.
module change_pulse_gen #(
    parameter int DEB_W      = 8,
    parameter int DEB_CYCLES = 100,
    parameter int RPT_W      = 16
) (
    input logic              clk,
    input logic              rst_n,
    change_pulse_gen_if.slave bus
);
    typedef enum logic {ST_STABLE, ST_CHECK} state_t;

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    state_t           state_q, state_d;
    logic [DEB_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             sync1_q, sync2_q;
    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             change_q, change_d;
    logic             accept;
    logic             rise_ok, fall_ok;
    logic             deb_strobe, rpt_on, rpt_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_STABLE;
            cnt_q    <= '0;
            level_q  <= 1'b0;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            rpt_q    <= '0;
            change_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            sync1_q  <= bus.raw_in;
            sync2_q  <= sync1_q;
            rpt_q    <= rpt_d;
            change_q <= change_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        accept  = 1'b0;
        case (state_q)
            ST_STABLE: begin
                if (sync2_q != level_q) begin
                    state_d = ST_CHECK;
                    cnt_d   = DEB_W'(1);
                end
            end
            ST_CHECK: begin
                if (sync2_q == level_q) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    accept  = 1'b1;
                    level_d = ~level_q;
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + DEB_W'(1);
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Repeat runs off the pre-update level; a simultaneous debounce strobe and
    // repeat expiry collapse into a single registered strobe.
    always_comb begin
        rise_ok    = (bus.edge_sel == 2'b00) || (bus.edge_sel == 2'b10);
        fall_ok    = (bus.edge_sel == 2'b01) || (bus.edge_sel == 2'b10);
        deb_strobe = accept && (level_d ? rise_ok : fall_ok);
        rpt_on     = level_q && bus.hold_en && (bus.rpt_period != '0) && rise_ok;
        rpt_fire   = rpt_on && (rpt_q == bus.rpt_period - RPT_W'(1));
        if (accept || !rpt_on || rpt_fire)
            rpt_d = '0;
        else
            rpt_d = rpt_q + RPT_W'(1);
        change_d = deb_strobe || rpt_fire;
    end

    assign bus.change = change_q;
    assign bus.level  = level_q;
    assign bus.busy   = (state_q == ST_CHECK);

`ifdef CHANGE_GEN_PULSE_CNT_EN
    logic [15:0] pulse_cnt_q;

    // Counts on change_d so the count moves on the same edge the strobe appears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pulse_cnt_q <= '0;
        else if (bus.cnt_clr)
            pulse_cnt_q <= '0;
        else if (change_d && (pulse_cnt_q != 16'hFFFF))
            pulse_cnt_q <= pulse_cnt_q + 16'd1;
    end

    assign bus.pulse_cnt = pulse_cnt_q;
`endif
endmodule
